mx_dot_sequencer: RTL and testbench
===================================

Name: mx_dot_sequencer

Overview:
- Streams one MX block of element pairs (sign, mantissa) under shared block exponents through a single mx_multiplier instance, one pair per cycle.
- Accumulates the signed products exactly in a fixed-point accumulator, then normalizes and rounds the sum to one BF16 result per block.
- Sits between the PE operand feed and the BF16 output/accumulation path. It replaces per-element BF16 conversion with one conversion per block.

Parameters:
- MANT_WIDTH, 5, explicit mantissa bits per element (hidden 1 added internally); product is 2*MANT_WIDTH+2 bits.
- MAX_LEN, 32, maximum elements per block. Localparam ACC_WIDTH = 2*MANT_WIDTH+3+$clog2(MAX_LEN), signed.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  element pair valid
- in_ready  out  1  sequencer can accept element
- in_sign_a, in_sign_b  in  1 each  element signs
- in_mant_a, in_mant_b  in  MANT_WIDTH each  element mantissas
- in_exp_a, in_exp_b  in  8 each  block exponents (biased 127), sampled on first element of block only
- in_last  in  1  final element of block
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_bf16  out  16  BF16 dot-product result
- len_err  out  1  sticky: a block reached MAX_LEN without in_last

Behaviour:
- Reset (async, rst_n low, any state): state=IDLE, in_ready=0, out_valid=0, out_bf16=0, len_err=0, accumulator=0, count=0. Release lands in IDLE. Reset mid-block discards the partial block.
- States: IDLE -> MAC on the first handshake (in_valid&in_ready). MAC -> NORM on the last handshake. NORM -> OUT after 1 cycle. OUT -> IDLE when out_valid&out_ready.
- in_ready=1 in IDLE and MAC only; 0 in NORM/OUT (backpressure). Handshake = in_valid&in_ready.
- First handshake: latch exp_a/exp_b; acc = signed product; count=1.
- Each further MAC handshake: acc += (sign_a^sign_b ? -P : +P), where P = {1,mant_a}*{1,mant_b}; count++. No handshake means no change (bubbles allowed).
- A block ends when in_last=1, or when count reaches MAX_LEN (forced end, sets len_err; len_err clears only on reset).
- in_last on the first element gives a 1-element block.
- NORM (combinational LZD + round, registered at the cycle end):
  - mag=|acc|, sign=acc<0.
  - k = index of the leading one.
  - E = k - 2*MANT_WIDTH + exp_a + exp_b - 127, 11-bit signed.
  - Mantissa = mag bits [k-1 -: 7], zero-padded below bit 0 when k<7. Round bit = mag[k-8] (0 if k<8).
  - Default rounding: round-half-up. A carry out of the 7 mantissa bits gives mantissa=0, E+1.
  - Checks are applied after rounding:
    - mag==0 -> 0x0000.
    - E<=0 -> {sign,15'b0} (flush).
    - E>=255 -> {sign,8'hFF,7'b0}.
    - Otherwise -> {sign,E[7:0],mant}.
- OUT: out_valid=1; out_bf16 stable while out_ready=0. Latency: out_valid rises 2 cycles after the last-element handshake.
- On OUT handshake: out_valid=0 next cycle, accumulator cleared, in_ready=1 next cycle. No overlap with the next block; throughput is N+2 cycles per block minimum.
- exp_a/exp_b on non-first elements are ignored.

Optional Feature:
- MX_DOT_RNE_EN defined: round-to-nearest-even. Guard = mag[k-8]; sticky = OR of mag below k-8; round up iff guard&(sticky|mant[0]).
- Undefined: round-half-up on guard only, matching the existing BF16 converter.
- Carry, overflow and flush handling are identical in both modes.

Decomposition:
- Shared package mx_pkg:
  - BF16_BIAS=127, BF16_EXP_MAX=255.
  - BF16 inf/zero constants.
  - State enum typedef {IDLE,MAC,NORM,OUT}.
- Reuse existing mx_multiplier for sign/product; its exponent output is unused.
- One new sub-module mx_norm_round: purely combinational, holds the LZD, exponent math, rounding and special cases. Instantiated once, in NORM.

Test Plan (MANT_WIDTH=5):
- One element, mants 0/0, exps 127/127, in_last -> out_bf16=0x3F80 exactly 2 cycles after handshake; len_err=0.
- Two elements (+1.0x1.0), (sign_a=1, 1.0x1.0) -> acc=0 -> 0x0000.
- One element, mants 16/16 (1.5x1.5), exps 127/127 -> 0x4010 (2.25).
- Three elements (31,31,+), (31,31,+), (29,31,sign_a=1), exps 127/127 -> acc=4095, rounding carry -> 0x4080 in both rounding modes.
- Special cases:
  - Exps 254/254, mants 0/0 -> 0x7F80.
  - Exps 1/1 -> 0x0000.
  - Negative single product at exps 1/1 -> 0x8000.
- Handshake and boundary checks:
  - Hold out_ready=0 for 5 cycles: out_bf16 stable, in_ready=0.
  - 32 elements with no in_last -> result emitted, len_err=1.
  - Assert rst_n low mid-MAC -> all outputs 0 immediately, next block correct.

Source files
------------

// File: rtl/mx_pkg.sv
// Shared definitions for the MX dot-product datapath: BF16 field limits,
// special encodings and the sequencer state type.
// Optional build macro: MX_DOT_RNE_EN (round-to-nearest-even in mx_norm_round).
package mx_pkg;

  localparam int BF16_BIAS    = 127;
  localparam int BF16_EXP_MAX = 255;

  localparam logic [15:0] BF16_ZERO    = 16'h0000;
  localparam logic [15:0] BF16_POS_INF = 16'h7F80;
  localparam logic [15:0] BF16_NEG_INF = 16'hFF80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    NORM = 2'd2,
    OUT  = 2'd3
  } seq_state_t;

  // Assemble a BF16 word from its three fields.
  function automatic logic [15:0] bf16_pack(input logic sign,
                                            input logic [7:0] exp,
                                            input logic [6:0] mant);
    return {sign, exp, mant};
  endfunction

endpackage

// File: rtl/mx_multiplier.sv
// MX element multiplier: sign XOR, significand product with the hidden one
// restored, and the unbiased sum of the two shared block exponents.
module mx_multiplier
  import mx_pkg::*;
#(
  parameter int MANT_WIDTH = 5
) (
  input  logic                    sign_a,
  input  logic                    sign_b,
  input  logic [MANT_WIDTH-1:0]   mant_a,
  input  logic [MANT_WIDTH-1:0]   mant_b,
  input  logic [7:0]              exp_a,
  input  logic [7:0]              exp_b,
  output logic                    prod_sign,
  output logic [2*MANT_WIDTH+1:0] prod_mant,
  output logic [9:0]              prod_exp
);

  localparam int PW = 2*MANT_WIDTH + 2;

  // Product of the two significands {1,mant}, sign and exponent sum.
  always_comb begin
    prod_sign = sign_a ^ sign_b;
    prod_mant = PW'({1'b1, mant_a}) * PW'({1'b1, mant_b});
    prod_exp  = {2'b00, exp_a} + {2'b00, exp_b} - 10'(BF16_BIAS);
  end

endmodule

// File: rtl/mx_norm_round.sv
// Combinational normalize-and-round of the signed block accumulator into
// one BF16 word: leading-one detect, exponent rebuild, 7-bit rounding and
// zero / flush / infinity handling.
// Optional build macro: MX_DOT_RNE_EN selects round-to-nearest-even;
// otherwise rounding is half-up on the guard bit alone.
module mx_norm_round
  import mx_pkg::*;
#(
  parameter int MANT_WIDTH = 5,
  parameter int ACC_WIDTH  = 18
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic [7:0]                  exp_a,
  input  logic [7:0]                  exp_b,
  output logic [15:0]                 bf16
);

  localparam int EXT_W = ACC_WIDTH + 8;
  localparam int K_W   = $clog2(ACC_WIDTH);

  logic                 sign;
  logic [ACC_WIDTH-1:0] mag;
  logic [K_W-1:0]       lead_idx;
  logic [K_W-1:0]       shamt;
  logic [EXT_W-1:0]     aligned;
  logic [6:0]           mant;
  logic                 guard;
  logic                 round_up;
  logic [7:0]           mant_rnd;
  logic signed [11:0]   exp_pre;
  logic signed [11:0]   exp_fin;
  logic [6:0]           mant_fin;
  int                   exp_int;

  assign sign = acc[ACC_WIDTH-1];
  assign mag  = sign ? $unsigned(-acc) : $unsigned(acc);

  // Leading-one detector: the highest set bit of the magnitude wins.
  always_comb begin
    lead_idx = '0;
    for (int i = 0; i < ACC_WIDTH; i++) begin
      if (mag[i]) lead_idx = K_W'(i);
    end
  end

  // Align the leading one to the top of an 8-bit-padded copy, so mantissa,
  // guard and sticky bits sit at fixed positions whatever the leading index.
  always_comb begin
    shamt   = K_W'(ACC_WIDTH - 1) - lead_idx;
    aligned = {mag, 8'b0} << shamt;
    mant    = aligned[EXT_W-2 -: 7];
    guard   = aligned[EXT_W-9];
`ifdef MX_DOT_RNE_EN
    round_up = guard & ((|aligned[EXT_W-10:0]) | mant[0]);
`else
    round_up = guard;
`endif
  end

  // Exponent rebuild, rounding carry and the special-case priority.
  always_comb begin
    exp_int  = int'(lead_idx) - 2*MANT_WIDTH + int'(exp_a) + int'(exp_b) - BF16_BIAS;
    exp_pre  = 12'(exp_int);
    mant_rnd = {1'b0, mant} + 8'(round_up);
    if (mant_rnd[7]) begin
      mant_fin = 7'd0;
      exp_fin  = exp_pre + 12'sd1;
    end else begin
      mant_fin = mant_rnd[6:0];
      exp_fin  = exp_pre;
    end

    if (mag == '0)
      bf16 = BF16_ZERO;
    else if (exp_fin <= 12'sd0)
      bf16 = {sign, 15'b0};
    else if (exp_fin >= 12'(BF16_EXP_MAX))
      bf16 = sign ? BF16_NEG_INF : BF16_POS_INF;
    else
      bf16 = bf16_pack(sign, exp_fin[7:0], mant_fin);
  end

endmodule

// File: rtl/mx_dot_sequencer.sv
// MX block dot-product sequencer: streams element pairs through one
// mx_multiplier, accumulates exact signed products, then converts the block
// sum to a single BF16 result with a valid/ready output handshake.
// Optional build macro: MX_DOT_RNE_EN (round-to-nearest-even in mx_norm_round).
module mx_dot_sequencer
  import mx_pkg::*;
#(
  parameter int MANT_WIDTH = 5,
  parameter int MAX_LEN    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign_a,
  input  logic                  in_sign_b,
  input  logic [MANT_WIDTH-1:0] in_mant_a,
  input  logic [MANT_WIDTH-1:0] in_mant_b,
  input  logic [7:0]            in_exp_a,
  input  logic [7:0]            in_exp_b,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [15:0]           out_bf16,
  output logic                  len_err
);

  localparam int ACC_WIDTH = 2*MANT_WIDTH + 3 + $clog2(MAX_LEN);
  localparam int PW        = 2*MANT_WIDTH + 2;
  localparam int CNT_W     = $clog2(MAX_LEN + 1);

  seq_state_t                  state, state_next;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]            count;
  logic [CNT_W-1:0]            count_next;
  logic [7:0]                  exp_a_q, exp_b_q;
  logic                        active;

  logic                        prod_sign;
  logic [PW-1:0]               prod_mant;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] prod_signed;
  logic [15:0]                 norm_bf16;

  logic                        in_hs;
  logic                        out_hs;
  logic                        first_elem;
  logic                        hit_max;
  logic                        block_end;

  mx_multiplier #(.MANT_WIDTH(MANT_WIDTH)) u_mult (
    .sign_a    (in_sign_a),
    .sign_b    (in_sign_b),
    .mant_a    (in_mant_a),
    .mant_b    (in_mant_b),
    .exp_a     (in_exp_a),
    .exp_b     (in_exp_b),
    .prod_sign (prod_sign),
    .prod_mant (prod_mant),
    .prod_exp  ()
  );

  mx_norm_round #(.MANT_WIDTH(MANT_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_norm (
    .acc   (acc),
    .exp_a (exp_a_q),
    .exp_b (exp_b_q),
    .bf16  (norm_bf16)
  );

  // Handshakes, signed product and block-end detection.
  always_comb begin
    in_hs       = in_valid & in_ready;
    out_hs      = out_valid & out_ready;
    first_elem  = (state == IDLE);
    count_next  = first_elem ? CNT_W'(1) : count + CNT_W'(1);
    hit_max     = (count_next == CNT_W'(MAX_LEN));
    block_end   = in_hs & (in_last | hit_max);
    prod_ext    = ACC_WIDTH'(prod_mant);
    prod_signed = prod_sign ? -prod_ext : prod_ext;
  end

  // State register; active holds in_ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= 1'b1;
    end
  end

  // Next-state logic: no overlap between blocks, NORM lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_hs) state_next = block_end ? NORM : MAC;
      MAC:  if (block_end) state_next = NORM;
      NORM: state_next = OUT;
      OUT:  if (out_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: input side open only in IDLE/MAC, result valid in OUT.
  always_comb begin
    in_ready  = active & ((state == IDLE) | (state == MAC));
    out_valid = (state == OUT);
  end

  // Accumulator, element count and block exponents; cleared once a result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      count   <= '0;
      exp_a_q <= '0;
      exp_b_q <= '0;
    end else if (in_hs) begin
      count <= count_next;
      if (first_elem) begin
        acc     <= prod_signed;
        exp_a_q <= in_exp_a;
        exp_b_q <= in_exp_b;
      end else begin
        acc <= acc + prod_signed;
      end
    end else if (out_hs) begin
      acc   <= '0;
      count <= '0;
    end
  end

  // Result register (loaded at the end of NORM) and sticky length-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bf16 <= '0;
      len_err  <= 1'b0;
    end else begin
      if (state == NORM) out_bf16 <= norm_bf16;
      if (in_hs & hit_max & ~in_last) len_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mx_dot_sequencer.sv
// Directed self-checking bench for mx_dot_sequencer (MANT_WIDTH=5, MAX_LEN=32).
// Build macro MX_DOT_RNE_EN changes only the expected value of the tie case.
module tb_mx_dot_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign_a = 1'b0, in_sign_b = 1'b0;
  logic [4:0]  in_mant_a = '0, in_mant_b = '0;
  logic [7:0]  in_exp_a = '0, in_exp_b = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_bf16;
  logic        len_err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mx_dot_sequencer #(.MANT_WIDTH(5), .MAX_LEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign_a (in_sign_a),
    .in_sign_b (in_sign_b),
    .in_mant_a (in_mant_a),
    .in_mant_b (in_mant_b),
    .in_exp_a  (in_exp_a),
    .in_exp_b  (in_exp_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bf16  (out_bf16),
    .len_err   (len_err)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one element pair for a single cycle (inputs change 1 time unit after a rising edge).
  task automatic applyStimulus(input logic sa, input logic [4:0] ma, input logic [7:0] ea,
                               input logic sb, input logic [4:0] mb, input logic [7:0] eb,
                               input logic last);
    checkOutput("in_ready_before_elem", 32'(in_ready), 32'd1);
    in_sign_a = sa; in_mant_a = ma; in_exp_a = ea;
    in_sign_b = sb; in_mant_b = mb; in_exp_b = eb;
    in_last   = last;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called one cycle after the last handshake: check the 2-cycle latency,
  // optionally stall the consumer, then take the result.
  task automatic collectResult(input string tag, input logic [15:0] exp, input int hold);
    checkOutput({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput(tag, 32'(out_bf16), 32'(exp));
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_hold_bf16"}, 32'(out_bf16), 32'(exp));
      checkOutput({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_bf16", 32'(out_bf16), 32'd0);
    checkOutput("rst_len_err", 32'(len_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1.0 x 1.0 at unit exponents -> 1.0
    applyStimulus(0, 5'd0, 8'd127, 0, 5'd0, 8'd127, 1);
    collectResult("one_elem", 16'h3F80, 0);
    checkOutput("one_elem_len_err", 32'(len_err), 32'd0);

    // +1 then -1 cancels to exact zero
    applyStimulus(0, 5'd0, 8'd127, 0, 5'd0, 8'd127, 0);
    applyStimulus(1, 5'd0, 8'd127, 0, 5'd0, 8'd127, 1);
    collectResult("cancel_zero", 16'h0000, 0);

    // 1.5 x 1.5 = 2.25
    applyStimulus(0, 5'd16, 8'd127, 0, 5'd16, 8'd127, 1);
    collectResult("one_p5_sq", 16'h4010, 0);

    // 3969+3969-3843 = 4095: rounding carry; later exponents must be ignored.
    // The consumer stalls 5 cycles here.
    applyStimulus(0, 5'd31, 8'd127, 0, 5'd31, 8'd127, 0);
    applyStimulus(0, 5'd31, 8'd3,   0, 5'd31, 8'd200, 0);
    applyStimulus(1, 5'd29, 8'd0,   0, 5'd31, 8'd0,   1);
    collectResult("carry_4095", 16'h4080, 5);

    // 36 x 58 = 2088: guard=1, sticky=0, lsb=0 -> tie case
`ifdef MX_DOT_RNE_EN
    applyStimulus(0, 5'd4, 8'd127, 0, 5'd26, 8'd127, 1);
    collectResult("tie_round", 16'h4002, 0);
`else
    applyStimulus(0, 5'd4, 8'd127, 0, 5'd26, 8'd127, 1);
    collectResult("tie_round", 16'h4003, 0);
`endif

    // Overflow, flush, negative flush
    applyStimulus(0, 5'd0, 8'd254, 0, 5'd0, 8'd254, 1);
    collectResult("overflow_inf", 16'h7F80, 0);
    applyStimulus(0, 5'd0, 8'd1, 0, 5'd0, 8'd1, 1);
    collectResult("flush_pos", 16'h0000, 0);
    applyStimulus(1, 5'd0, 8'd1, 0, 5'd0, 8'd1, 1);
    collectResult("flush_neg", 16'h8000, 0);
    checkOutput("pre_max_len_err", 32'(len_err), 32'd0);

    // 32 x (1.0 x 1.0) without in_last: forced end, 32768 -> 0x4200
    for (int i = 0; i < 32; i++)
      applyStimulus(0, 5'd0, 8'd127, 0, 5'd0, 8'd127, 0);
    checkOutput("max_len_err_set", 32'(len_err), 32'd1);
    collectResult("max_len", 16'h4200, 0);
    checkOutput("max_len_err_sticky", 32'(len_err), 32'd1);

    // Reset in the middle of a block discards it and clears everything
    applyStimulus(0, 5'd31, 8'd127, 0, 5'd31, 8'd127, 0);
    applyStimulus(0, 5'd31, 8'd127, 0, 5'd31, 8'd127, 0);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_bf16", 32'(out_bf16), 32'd0);
    checkOutput("midrst_len_err", 32'(len_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 5'd16, 8'd127, 0, 5'd16, 8'd127, 1);
    collectResult("after_rst", 16'h4010, 0);
    checkOutput("after_rst_len_err", 32'(len_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
